// File: rtl/sonar_amostrador.sv
// Periodic trigger and averaging sampler for the HC-SR04 interface: fires medir on a fixed
// grid, waits for pronto with a timeout, publishes the mean of 2^N_LOG2 samples. Optional range filter: SONAR_FILTRO_FAIXA_EN.
module sonar_amostrador #(
   parameter int DW             = 12,
   parameter int PERIOD_CYCLES  = 2500000,
   parameter int TIMEOUT_CYCLES = 1500000,
   parameter int N_LOG2         = 2,
   parameter int DIST_MAX       = 400
) (
   input  logic          clock_i,
   input  logic          reset_i,
   input  logic          ligar_i,
   input  logic          pronto_i,
   input  logic [DW-1:0] medida_i,
   output logic          medir_o,
   output logic [DW-1:0] distancia_o,
   output logic          valido_o,
   output logic          falha_o,
   output logic [3:0]    db_estado_o
);

   // state     | meaning
   // INICIAL   | idle, window cleared, waiting for ligar
   // DISPARA   | one-cycle medir pulse, timers reloaded
   // ESPERA    | waiting for pronto or timeout
   // MEDIA     | window full, publish average on exit
   // INTERVALO | waiting for the end of the period grid
   typedef enum logic [2:0] {
      INICIAL   = 3'd0,
      DISPARA   = 3'd1,
      ESPERA    = 3'd2,
      INTERVALO = 3'd3,
      MEDIA     = 3'd4
   } estado_t;

   localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int AW = DW + N_LOG2;
   localparam logic [PW-1:0] PerLoad = PW'(PERIOD_CYCLES - 1);
   localparam logic [TW-1:0] ToLoad  = TW'(TIMEOUT_CYCLES - 1);

`ifdef SONAR_FILTRO_FAIXA_EN
   localparam bit FiltroEn = 1'b1;
`else
   localparam bit FiltroEn = 1'b0;
`endif

   estado_t           estado_q, estado_d;
   logic [PW-1:0]     per_q, per_d;
   logic [TW-1:0]     to_q, to_d;
   logic [AW-1:0]     acc_q, acc_d;
   logic [N_LOG2-1:0] cnt_q, cnt_d;
   logic [DW-1:0]     dist_q, dist_d;
   logic              valido_q, valido_d;
   logic              falha_q, falha_d;
   logic              fora_faixa;

   // Both timers count down so that each reads its terminal value of zero exactly
   // PERIOD_CYCLES-1 / TIMEOUT_CYCLES-1 cycles after the DISPARA cycle.
   assign fora_faixa = FiltroEn && ((medida_i == '0) || (int'(medida_i) > DIST_MAX));

   always_comb begin
      estado_d    = estado_q;
      per_d       = per_q;
      to_d        = to_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      dist_d      = dist_q;
      valido_d    = 1'b0;
      falha_d     = falha_q;
      medir_o     = 1'b0;
      db_estado_o = 4'hE;

      case (estado_q)
         INICIAL: begin
            db_estado_o = 4'h0;
            acc_d       = '0;
            cnt_d       = '0;
            if (ligar_i) begin
               estado_d = DISPARA;
               per_d    = PerLoad;
               to_d     = ToLoad;
            end
         end
         DISPARA: begin
            db_estado_o = 4'h1;
            medir_o     = 1'b1;
            per_d       = per_q - PW'(1);
            to_d        = to_q - TW'(1);
            estado_d    = ESPERA;
         end
         ESPERA: begin
            db_estado_o = 4'h2;
            per_d       = per_q - PW'(1);
            to_d        = to_q - TW'(1);
            if (pronto_i) begin
               if (fora_faixa) begin
                  falha_d  = 1'b1;
                  estado_d = INTERVALO;
               end else begin
                  acc_d    = acc_q + AW'(medida_i);
                  cnt_d    = cnt_q + N_LOG2'(1);
                  falha_d  = 1'b0;
                  estado_d = (cnt_q == '1) ? MEDIA : INTERVALO;
               end
            end else if (to_q == '0) begin
               falha_d  = 1'b1;
               estado_d = INTERVALO;
            end
         end
         MEDIA: begin
            db_estado_o = 4'h4;
            per_d       = per_q - PW'(1);
            dist_d      = acc_q[AW-1:N_LOG2];
            valido_d    = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            estado_d    = INTERVALO;
         end
         INTERVALO: begin
            db_estado_o = 4'h3;
            if (per_q == '0) begin
               estado_d = DISPARA;
               per_d    = PerLoad;
               to_d     = ToLoad;
            end else begin
               per_d = per_q - PW'(1);
            end
         end
         default: begin
            db_estado_o = 4'hE;
            estado_d    = INICIAL;
         end
      endcase

      // Disable aborts the window but keeps the last published result and fault flag.
      if ((estado_q != INICIAL) && !ligar_i) begin
         estado_d = INICIAL;
         acc_d    = '0;
         cnt_d    = '0;
         dist_d   = dist_q;
         valido_d = 1'b0;
         falha_d  = falha_q;
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         estado_q <= INICIAL;
         per_q    <= '0;
         to_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         dist_q   <= '0;
         valido_q <= 1'b0;
         falha_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         per_q    <= per_d;
         to_q     <= to_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         dist_q   <= dist_d;
         valido_q <= valido_d;
         falha_q  <= falha_d;
      end
   end

   assign distancia_o = dist_q;
   assign valido_o    = valido_q;
   assign falha_o     = falha_q;

endmodule

// File: tb/tb_sonar_amostrador.sv
// Bench for sonar_amostrador: reset/start vector table, then per-period scenarios checked
// cycle by cycle against a period-level model of trigger grid, fault flag and averages.
module tb_sonar_amostrador;

   localparam int DW = 12;
   localparam int P  = 100;
   localparam int T  = 60;
   localparam int NL = 2;

   logic          clk = 1'b0;
   logic          reset, ligar, pronto;
   logic [DW-1:0] medida;
   logic          medir, valido, falha;
   logic [DW-1:0] distancia;
   logic [3:0]    db_estado;

   int checks   = 0;
   int failures = 0;

   int m_acc  = 0;
   int m_cnt  = 0;
   int m_dist = 0;
   int m_falha = 0;

   sonar_amostrador #(
      .DW(DW), .PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T), .N_LOG2(NL), .DIST_MAX(400)
   ) dut (
      .clock_i    (clk),
      .reset_i    (reset),
      .ligar_i    (ligar),
      .pronto_i   (pronto),
      .medida_i   (medida),
      .medir_o    (medir),
      .distancia_o(distancia),
      .valido_o   (valido),
      .falha_o    (falha),
      .db_estado_o(db_estado)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          lig;
      logic          pr;
      logic [DW-1:0] med;
      logic          e_medir;
      logic          e_valido;
      logic          e_falha;
      logic [3:0]    e_db;
      logic [DW-1:0] e_dist;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   function automatic bit in_range(input int v);
`ifdef SONAR_FILTRO_FAIXA_EN
      return (v >= 1) && (v <= 400);
`else
      return 1'b1;
`endif
   endfunction

   // One measurement period, entered just after the edge that starts the DISPARA cycle.
   // d = cycle offset of pronto after medir (0 = no pronto), stray = offset of an extra pronto in INTERVALO.
   task automatic run_period(input int d, input int v, input int stray);
      bit ok, fourth, exp_v;
      int end_esp, exp_db;
      ok      = (d > 0) && in_range(v);
      fourth  = ok && (m_cnt == (1 << NL) - 1);
      end_esp = (d > 0) ? d : T - 1;
      for (int k = 0; k < P; k++) begin
         pronto = 1'b0;
         medida = DW'($urandom_range(0, 4095));
         if (d > 0 && k == d) begin
            pronto = 1'b1;
            medida = DW'(v);
         end else if (stray > 0 && k == stray) begin
            pronto = 1'b1;
            medida = DW'(999);
         end
         if (d > 0 && k == d + 1) begin
            if (ok) begin
               m_falha = 0;
               m_acc  += v;
               m_cnt++;
            end else begin
               m_falha = 1;
            end
         end
         if (d == 0 && k == T) m_falha = 1;
         exp_v = fourth && (k == d + 2);
         if (exp_v) begin
            m_dist = m_acc >> NL;
            m_acc  = 0;
            m_cnt  = 0;
         end
         exp_db = (k == 0) ? 1 : (k <= end_esp) ? 2 : (fourth && k == end_esp + 1) ? 4 : 3;
         @(negedge clk);
         chk("medir", medir, (k == 0));
         chk("valido", valido, exp_v);
         chk("falha", falha, m_falha);
         chk("distancia", distancia, m_dist);
         chk("db_estado", db_estado, exp_db);
         @(posedge clk); #1;
      end
      pronto = 1'b0;
   endtask

   task automatic start_seq();
      ligar = 1'b1;
      @(posedge clk); #1;
   endtask

   // Entered at the start of a DISPARA cycle; drops ligar and checks the held outputs.
   task automatic stop_seq();
      ligar = 1'b0;
      @(negedge clk);
      chk("stop_medir", medir, 1);
      @(posedge clk); #1;
      m_acc = 0;
      m_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stop_db", db_estado, 0);
         chk("stop_medir_idle", medir, 0);
         chk("stop_valido", valido, 0);
         chk("stop_distancia", distancia, m_dist);
         chk("stop_falha", falha, m_falha);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      reset  = 1'b0;
      ligar  = 1'b0;
      pronto = 1'b0;
      medida = '0;

      //          rst   lig   pr    med     medir valido falha db    dist
      tbl[0] = '{1'b0, 1'b1, 1'b1, 12'd77, 1'b0, 1'b0, 1'b0, 4'h0, 12'd0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 12'd77, 1'b0, 1'b0, 1'b0, 4'h0, 12'd0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 12'd0,  1'b0, 1'b0, 1'b0, 4'h0, 12'd0};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 12'd55, 1'b0, 1'b0, 1'b0, 4'h0, 12'd0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 12'd0,  1'b0, 1'b0, 1'b0, 4'h0, 12'd0};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 12'd0,  1'b1, 1'b0, 1'b0, 4'h1, 12'd0};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 12'd0,  1'b0, 1'b0, 1'b0, 4'h2, 12'd0};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 12'd33, 1'b0, 1'b0, 1'b0, 4'h0, 12'd0};
      tbl[8] = '{1'b0, 1'b1, 1'b0, 12'd0,  1'b0, 1'b0, 1'b0, 4'h0, 12'd0};

      for (int i = 0; i < 9; i++) begin
         reset  = tbl[i].rst;
         ligar  = tbl[i].lig;
         pronto = tbl[i].pr;
         medida = tbl[i].med;
         @(posedge clk);
         @(negedge clk);
         chk("tbl_medir", medir, tbl[i].e_medir);
         chk("tbl_valido", valido, tbl[i].e_valido);
         chk("tbl_falha", falha, tbl[i].e_falha);
         chk("tbl_db", db_estado, tbl[i].e_db);
         chk("tbl_distancia", distancia, tbl[i].e_dist);
      end

      reset  = 1'b1;
      pronto = 1'b0;
      start_seq();

      // Averaging window: 100,101,102,104 -> 101
      run_period(10, 100, 0);
      run_period(10, 101, 0);
      run_period(10, 102, 0);
      run_period(10, 104, 0);
      chk("avg_first_window", distancia, 101);

      // Timeout on 2nd medir, stray pronto in INTERVALO, pronto on the terminal timeout cycle
      run_period(10, 200, 0);
      run_period(0, 0, 0);
      run_period(20, 300, 80);
      run_period(30, 400, 0);
      run_period(T - 1, 500, 90);
      chk("avg_with_timeout", distancia, 350);
      chk("falha_after_terminal_pronto", falha, 0);

      // Disable after two accepted samples, then a fresh window of 50s
      run_period(10, 900, 0);
      run_period(10, 900, 0);
      stop_seq();
      start_seq();
      for (int i = 0; i < 4; i++) run_period(15, 50, 0);
      chk("avg_after_reenable", distancia, 50);

      // Random periods against the model
      for (int i = 0; i < 8; i++) begin
         int d, v, s;
         d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, T - 1));
         v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 450));
         s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(70, 98)) : 0;
         run_period(d, v, s);
      end
      stop_seq();
      start_seq();

      // Range-filter sequence: both builds publish 200 here
      run_period(10, 0, 0);
      run_period(10, 401, 0);
      for (int i = 0; i < 4; i++) run_period(10, 200, 0);
      chk("filter_seq_avg", distancia, 200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
